matmul_sequencer: RTL and testbench

- Bus-master sequencer in front of the main memory block.
- Drives its memread/memwrite/address/data_in inputs and consumes data_out to compute C = A x B on N x N unsigned 32-bit matrices.
- Memory map: A at A_BASE, B at B_BASE, C at C_BASE.
- Replaces the software inner loop for the matrix-multiply workload; one start pulse runs the full product and writes C back to memory.

---
 rtl/matmul_pkg.sv | 30 +++
 rtl/matmul_sequencer_if.sv | 30 +++
 rtl/matmul_sequencer_addr_gen.sv | 31 +++
 rtl/matmul_sequencer.sv | 125 ++++++++++++
 tb/tb_matmul_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
// Latency: n/a (types, constants and a pure address helper only).
// Backpressure: n/a.
package matmul_pkg;

  // Sequencer states: fetch A element, fetch B element and MAC, write C element, completion pulse.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [31:0] A_BASE_DEF = 32'h0000_0200;
  localparam logic [31:0] B_BASE_DEF = 32'h0000_0300;
  localparam logic [31:0] C_BASE_DEF = 32'h0000_0100;

  // Byte stride between consecutive 32-bit words.
  localparam int unsigned WORD_BYTES = 4;

  // Byte address of element [row][col] of a row-major n x n matrix at base.
  function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                            input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned n);
    return base + WORD_BYTES * (row * n + col);
  endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Memory bus between the sequencer (master) and the main memory block (slave).
// Latency: read data is combinational, valid in the same cycle as mem_read.
// Backpressure: none; memory accepts one read or one write every cycle.
// Signals: mem_read/mem_write strobes, mem_addr byte address, mem_wdata write data,
//          mem_rdata read data returned by memory.
interface matmul_sequencer_if #(
  parameter int DW = 32
);
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/matmul_sequencer_addr_gen.sv
// Maps (state, i, j, k) to the byte address the sequencer presents on the bus.
// Latency: purely combinational.
// Backpressure: n/a.
// Ports: state/i/j/k in, addr out (0 in states that make no access).
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int          N      = 3,
  parameter int          IW     = 2,
  parameter logic [31:0] A_BASE = A_BASE_DEF,
  parameter logic [31:0] B_BASE = B_BASE_DEF,
  parameter logic [31:0] C_BASE = C_BASE_DEF
) (
  input  state_t        state,
  input  logic [IW-1:0] i,
  input  logic [IW-1:0] j,
  input  logic [IW-1:0] k,
  output logic [31:0]   addr
);

  always_comb begin
    addr = '0;
    case (state)
      RD_A:    addr = elem_addr(A_BASE, 32'(i), 32'(k), N);
      RD_B:    addr = elem_addr(B_BASE, 32'(k), 32'(j), N);
      WR:      addr = elem_addr(C_BASE, 32'(i), 32'(j), N);
      default: addr = '0;
    endcase
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Bus-master sequencer computing C = A x B (N x N, unsigned, wrapping) over the memory bus.
// Latency: 2N+1 cycles per C element; N*N*(2N+1)+1 busy cycles per run (64 for N=3).
// Backpressure: none on the bus; start is ignored while busy (including the DONE cycle).
// Ports: clk, rst_n (sync, active-low), start in; busy, done out; mem = bus master modport.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int          N      = 3,
  parameter int          DW     = 32,
  parameter logic [31:0] A_BASE = A_BASE_DEF,
  parameter logic [31:0] B_BASE = B_BASE_DEF,
  parameter logic [31:0] C_BASE = C_BASE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  matmul_sequencer_if.master mem
);

  localparam int            IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state, n_state;
  logic [IW-1:0] i, j, k, n_i, n_j, n_k;
  logic [DW-1:0] acc, n_acc, a_reg, n_a_reg;
  logic [31:0]   n_addr;

  // Next-state and datapath update. Outputs are registered from these next
  // values, so every output flop always reflects the state it is paired with
  // and mem_rdata answers the address currently on the bus.
  always_comb begin
    n_state = state;
    n_i     = i;
    n_j     = j;
    n_k     = k;
    n_acc   = acc;
    n_a_reg = a_reg;
    case (state)
      IDLE: begin
        if (start) begin
          n_state = RD_A;
          n_i     = '0;
          n_j     = '0;
          n_k     = '0;
          n_acc   = '0;
        end
      end
      RD_A: begin
        n_a_reg = mem.mem_rdata;
        n_state = RD_B;
      end
      RD_B: begin
        // Low DW bits of the product; the sum wraps modulo 2^DW.
        n_acc = acc + a_reg * mem.mem_rdata;
        if (k != LAST) begin
          n_k     = k + 1'b1;
          n_state = RD_A;
        end else begin
          n_state = WR;
        end
      end
      WR: begin
        n_acc = '0;
        n_k   = '0;
        if (j != LAST) begin
          n_j = j + 1'b1;
        end else begin
          n_j = '0;
          n_i = (i == LAST) ? '0 : i + 1'b1;
        end
        n_state = (i == LAST && j == LAST) ? DONE : RD_A;
      end
      DONE:    n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end

  matmul_addr_gen #(
    .N      (N),
    .IW     (IW),
    .A_BASE (A_BASE),
    .B_BASE (B_BASE),
    .C_BASE (C_BASE)
  ) u_addr_gen (
    .state (n_state),
    .i     (n_i),
    .j     (n_j),
    .k     (n_k),
    .addr  (n_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      acc           <= '0;
      a_reg         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem.mem_read  <= 1'b0;
      mem.mem_write <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      state         <= n_state;
      i             <= n_i;
      j             <= n_j;
      k             <= n_k;
      acc           <= n_acc;
      a_reg         <= n_a_reg;
      busy          <= (n_state != IDLE);
      done          <= (n_state == DONE);
      mem.mem_read  <= (n_state == RD_A) || (n_state == RD_B);
      mem.mem_write <= (n_state == WR);
      mem.mem_addr  <= n_addr;
      // Entering WR the final RD_B sum is n_acc, not yet acc.
      mem.mem_wdata <= (n_state == WR) ? n_acc : '0;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Randomised scoreboard bench for matmul_sequencer (N=3) with a word-array memory model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_matmul_sequencer;
  localparam int          N  = 3;
  localparam int          NN = N * N;
  localparam logic [31:0] AB = 32'h0000_0200;
  localparam logic [31:0] BB = 32'h0000_0300;
  localparam logic [31:0] CB = 32'h0000_0100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  matmul_sequencer_if #(.DW(32)) bus ();

  matmul_sequencer #(
    .N      (N),
    .DW     (32),
    .A_BASE (AB),
    .B_BASE (BB),
    .C_BASE (CB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .mem   (bus)
  );

  always #5 clk = ~clk;

  // Word-addressed memory covering byte addresses 0x000..0x3FC.
  logic [31:0] mem_arr [0:255];
  assign bus.mem_rdata = bus.mem_read ? mem_arr[bus.mem_addr[9:2]] : 32'h0;

  logic [31:0] ma [0:NN-1];
  logic [31:0] mb [0:NN-1];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int total_reads = 0;
  int total_writes = 0;
  int done_count = 0;
  int reads_since_write = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the whole product, row-major, pushed as the expected write stream.
  task automatic push_expected();
    logic [31:0] sum;
    wr_t w;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        sum = 32'h0;
        for (int x = 0; x < N; x++) sum = sum + ma[r*N+x] * mb[x*N+c];
        w.addr = CB + 32'(4 * (r * N + c));
        w.data = sum;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic load_mem();
    for (int e = 0; e < NN; e++) begin
      mem_arr[int'(AB >> 2) + e] = ma[e];
      mem_arr[int'(BB >> 2) + e] = mb[e];
    end
  endtask

  task automatic rand_mats();
    for (int e = 0; e < NN; e++) begin
      ma[e] = $urandom;
      mb[e] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
    end
  endtask

  // Protocol monitor and scoreboard, sampled on the falling edge.
  logic in_a, in_b;
  always @(negedge clk) begin
    if (rst_n) begin
      check("strobe_exclusive", 64'(bus.mem_read & bus.mem_write), 64'(0));
      if (!bus.mem_read && !bus.mem_write)
        check("quiet_bus", {bus.mem_addr, bus.mem_wdata}, 64'(0));
      if (bus.mem_read) begin
        in_a = (bus.mem_addr >= AB) && (bus.mem_addr < AB + 32'(4 * NN)) && (bus.mem_addr[1:0] == 2'b00);
        in_b = (bus.mem_addr >= BB) && (bus.mem_addr < BB + 32'(4 * NN)) && (bus.mem_addr[1:0] == 2'b00);
        check("read_region_alternates", 64'(reads_since_write[0] ? in_b : in_a), 64'(1));
        reads_since_write++;
        total_reads++;
      end
      if (bus.mem_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(1), 64'(0));
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("write_addr", 64'(bus.mem_addr), 64'(w.addr));
          check("write_data", 64'(bus.mem_wdata), 64'(w.data));
        end
        check("reads_per_write", 64'(reads_since_write), 64'(2 * N));
        reads_since_write = 0;
        total_writes++;
      end
      if (!busy) reads_since_write = 0;
      if (done) begin
        done_count++;
        check("done_implies_busy", 64'(busy), 64'(1));
      end
    end
  end

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  // Called on the negedge of busy cycle 1; returns the busy-cycle index at which done is seen.
  task automatic wait_done(input bit repulse, output int n, output bit got);
    n = 1;
    got = 1'b0;
    while (n < 200) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
      if (repulse) start = (n == 5) || (n == 63) || (n == 64);
    end
  endtask

  task automatic run_full(input string tag, input bit repulse);
    int  w0, r0, d0, n;
    bit  got;
    w0 = total_writes;
    r0 = total_reads;
    d0 = done_count;
    push_expected();
    start_pulse();
    wait_done(repulse, n, got);
    check({tag, ":done_seen"}, 64'(got), 64'(1));
    check({tag, ":busy_cycles_to_done"}, 64'(n), 64'(N * N * (2 * N + 1) + 1));
    @(negedge clk);
    start = 1'b0;
    check({tag, ":done_single_pulse"}, 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    check({tag, ":writes"}, 64'(total_writes - w0), 64'(NN));
    check({tag, ":reads"}, 64'(total_reads - r0), 64'(2 * N * NN));
    check({tag, ":done_count"}, 64'(done_count - d0), 64'(1));
    check({tag, ":queue_drained"}, 64'(exp_q.size()), 64'(0));
    check({tag, ":idle_after_run"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int  n, w0, d0;
    bit  got;
    for (int a = 0; a < 256; a++) mem_arr[a] = 32'h0;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({busy, done, bus.mem_read, bus.mem_write}), 64'(0));
    check("reset_bus", {bus.mem_addr, bus.mem_wdata}, 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_busy", 64'(busy), 64'(0));

    // A = 1..9, B = identity.
    for (int e = 0; e < NN; e++) begin
      ma[e] = 32'(e + 1);
      mb[e] = (e % (N + 1) == 0) ? 32'h1 : 32'h0;
    end
    load_mem();
    run_full("identity", 1'b0);

    // A = 1..9, B = 1..9.
    for (int e = 0; e < NN; e++) mb[e] = 32'(e + 1);
    load_mem();
    run_full("seq_x_seq", 1'b0);

    // Wrapping: 0x8000_0000 * 2 summed three times wraps to 0.
    for (int e = 0; e < NN; e++) begin
      ma[e] = (e < N) ? 32'h8000_0000 : 32'h0;
      mb[e] = 32'h2;
    end
    load_mem();
    run_full("overflow", 1'b0);

    // Random operands, then random with start re-pulsed while busy.
    rand_mats();
    load_mem();
    run_full("random", 1'b0);
    rand_mats();
    load_mem();
    run_full("repulse", 1'b1);

    // start held high: a second run begins straight after the IDLE cycle.
    rand_mats();
    load_mem();
    push_expected();
    push_expected();
    w0 = total_writes;
    d0 = done_count;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_done(1'b0, n, got);
    check("held:first_done", 64'(got), 64'(1));
    check("held:first_cycles", 64'(n), 64'(64));
    @(negedge clk);
    check("held:idle_gap", 64'(busy), 64'(0));
    @(negedge clk);
    check("held:restart", 64'(busy), 64'(1));
    start = 1'b0;
    wait_done(1'b0, n, got);
    check("held:second_done", 64'(got), 64'(1));
    check("held:second_cycles", 64'(n), 64'(64));
    repeat (3) @(negedge clk);
    check("held:writes", 64'(total_writes - w0), 64'(2 * NN));
    check("held:done_count", 64'(done_count - d0), 64'(2));
    check("held:queue_drained", 64'(exp_q.size()), 64'(0));

    // Reset in the middle of a run, then a clean full run.
    rand_mats();
    load_mem();
    push_expected();
    start_pulse();
    n = 1;
    while (n < 30) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_ctrl", 64'({busy, done, bus.mem_read, bus.mem_write}), 64'(0));
    check("midreset_bus", {bus.mem_addr, bus.mem_wdata}, 64'(0));
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("midreset_stays_idle", 64'(busy), 64'(0));
    run_full("after_reset", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
